mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Sequencer/arbiter for the single byte-wide RAM port, shared by instruction fetch (IF) and the
//  MEM stage. Each granted request is split into 1/2/4 byte accesses. Read data is reassembled
//  little-endian and returned with a one-cycle done pulse. IF and MEM hold their requests until done.
// PARAMETERS
//  ADDR_W    32  width of all address ports
//  MEM_PRIO  1   1: MEM wins a simultaneous request; 0: IF wins
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       synchronous reset, active-high
//  if_req     in   1       IF word-read request, level, held until if_done
//  if_addr    in   ADDR_W  IF byte address (no alignment required)
//  if_rdata   out  32      fetched word, valid while if_done=1
//  if_done    out  1       1-cycle completion pulse for IF
//  mem_req    in   1       MEM request, level, held until mem_done
//  mem_we     in   1       1: store, 0: load
//  mem_len    in   2       0: byte, 1: half, 2 or 3: word
//  mem_addr   in   ADDR_W  MEM byte address
//  mem_wdata  in   32      store data; byte n = mem_wdata[8n+7:8n]
//  mem_rdata  out  32      raw load bytes, unused upper bytes zero, valid while mem_done=1
//  mem_done   out  1       1-cycle completion pulse for MEM
//  ram_addr   out  ADDR_W  RAM byte address (registered)
//  ram_dout   out  8       RAM write byte (registered)
//  ram_wr     out  1       RAM write strobe (registered); 0 means read
//  ram_din    in   8       RAM read byte for the address driven in the previous cycle
//  busy       out  1       1 in any state other than IDLE
// BEHAVIOUR
//  - Reset: state=IDLE. All outputs are 0: ram_addr, ram_dout, ram_wr, if/mem_rdata, if/mem_done, busy.
//  - Reset mid-transaction aborts it. ram_wr is 0 in the next cycle and no done pulse is issued.
//  - States: IDLE, RD, WR, DONE. A byte counter cnt[2:0] is used. N = 1/2/4 from mem_len; N = 4 for IF.
//  - IDLE: requests are sampled only in this state. Grant follows MEM_PRIO.
//    - On grant (edge closing cycle G): latch owner, base address, N, we and wdata.
//    - Set ram_addr <= base and cnt <= 0.
//    - A store also sets ram_wr <= 1 and ram_dout <= wdata[7:0], then enters WR. A load enters RD.
//  - No preemption: the other requester waits in IDLE until the current transaction finishes.
//  - WR: byte n is on the port in cycle G+1+n with ram_wr=1.
//    - After byte N-1: ram_wr <= 0, ram_addr <= 0, then enter DONE.
//    - Done is visible in cycle G+1+N (word store: G+5).
//  - RD: address for byte n is driven in cycle G+1+n. ram_din is captured into byte n at the end of cycle G+2+n.
//    - After the last address, ram_addr <= 0.
//    - After the last capture, enter DONE. Done is visible in cycle G+2+N (word load: G+6, byte load: G+3).
//  - DONE: exactly one cycle. The owner's done=1 and its rdata is stable. Then return to IDLE.
//    - No grant is made in DONE. The requester deasserts req (or issues a new one) for the next IDLE sample.
//  - rdata holds its value until the next completion for the same owner.
//  - Address arithmetic: base+n modulo 2^ADDR_W (wraps from all-ones to 0).
//  - No extension is done here; sign/zero extension belongs to the MEM stage.
//  - ram_wr is never 1 while in RD, IDLE or DONE.
// TESTING
//  - IF alone, if_addr=0x100, RAM[0x100..0x103]=11,22,33,44 -> ram_addr 0x100..0x103 on consecutive cycles;
//    if_done in cycle G+6 with if_rdata=0x44332211.
//  - MEM word store, addr=0x200, wdata=0xDEADBEEF -> ram_wr=1 for 4 cycles with bytes EF,BE,AD,DE at 0x200..0x203;
//    mem_done at G+5; read-back returns 0xDEADBEEF.
//  - if_req and mem_req asserted in the same cycle, MEM_PRIO=1 -> MEM byte load completes first;
//    IF is granted in the IDLE cycle right after DONE; if_done follows 6 cycles later.
//  - MEM half load at 0xFFFFFFFF -> bytes from 0xFFFFFFFF then 0x00000000; mem_rdata[31:16]=0.
//  - rst asserted in the second WR cycle of a word store -> next cycle ram_wr=0, busy=0, no mem_done;
//    only 2 bytes are written.
//  - mem_len=3 -> behaves exactly as a word access.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - IF/MEM request ports and the shared byte-wide RAM port of mem_arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              if_done;
  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_len;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_done;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_dout;
  logic              ram_wr;
  logic [7:0]        ram_din;
  logic              busy;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
    output if_rdata, if_done, mem_rdata, mem_done, ram_addr, ram_dout, ram_wr, busy
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
    input  if_rdata, if_done, mem_rdata, mem_done, ram_addr, ram_dout, ram_wr, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates IF and MEM onto one byte-wide RAM port, splitting accesses into bytes
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter bit MEM_PRIO = 1'b1
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

  state_e            state_q, state_d;
  logic              owner_mem_q, owner_mem_d;
  logic [2:0]        n_q, n_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rbuf_q, rbuf_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic [7:0]        dout_q, dout_d;
  logic              wr_q, wr_d;

  logic              grant_mem, grant_if, start_we;
  logic [2:0]        cnt_nxt;
  logic [1:0]        cap_idx;

  assign grant_mem = bus.mem_req && (MEM_PRIO || !bus.if_req);
  assign grant_if  = bus.if_req && !grant_mem;
  assign start_we  = grant_mem && bus.mem_we;
  assign cnt_nxt   = cnt_q + 3'd1;
  // In RD, cnt counts issued addresses; the byte landing now belongs to cnt-1.
  assign cap_idx   = cnt_q[1:0] - 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_mem_q <= 1'b0;
      n_q         <= 3'd0;
      cnt_q       <= 3'd0;
      base_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      rbuf_q      <= 32'd0;
      if_rdata_q  <= 32'd0;
      mem_rdata_q <= 32'd0;
      dout_q      <= 8'd0;
      wr_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_mem_q <= owner_mem_d;
      n_q         <= n_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      dout_q      <= dout_d;
      wr_q        <= wr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_mem_d = owner_mem_q;
    n_d         = n_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    dout_d      = dout_q;
    wr_d        = wr_q;
    unique case (state_q)
      IDLE: begin
        if (grant_mem || grant_if) begin
          owner_mem_d = grant_mem;
          base_d      = grant_mem ? bus.mem_addr : bus.if_addr;
          if (!grant_mem)               n_d = 3'd4;
          else if (bus.mem_len == 2'd0) n_d = 3'd1;
          else if (bus.mem_len == 2'd1) n_d = 3'd2;
          else                          n_d = 3'd4;
          wdata_d     = bus.mem_wdata;
          addr_d      = base_d;
          cnt_d       = 3'd0;
          rbuf_d      = 32'd0;
          if (start_we) begin
            wr_d    = 1'b1;
            dout_d  = bus.mem_wdata[7:0];
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      WR: begin
        if (cnt_nxt < n_q) begin
          cnt_d  = cnt_nxt;
          addr_d = base_q + ADDR_W'(cnt_nxt);
          dout_d = wdata_q[{cnt_nxt[1:0], 3'b000} +: 8];
        end else begin
          wr_d    = 1'b0;
          addr_d  = '0;
          state_d = DONE;
        end
      end
      RD: begin
        if (cnt_q != 3'd0) rbuf_d[{cap_idx, 3'b000} +: 8] = bus.ram_din;
        if (cnt_q == n_q) begin
          state_d = DONE;
          if (owner_mem_q) mem_rdata_d = rbuf_d;
          else             if_rdata_d  = rbuf_d;
        end else begin
          cnt_d  = cnt_nxt;
          addr_d = (cnt_nxt < n_q) ? base_q + ADDR_W'(cnt_nxt) : '0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ram_addr  = addr_q;
    bus.ram_dout  = dout_q;
    bus.ram_wr    = wr_q;
    bus.if_rdata  = if_rdata_q;
    bus.mem_rdata = mem_rdata_q;
    bus.if_done   = (state_q == DONE) && !owner_mem_q;
    bus.mem_done  = (state_q == DONE) && owner_mem_q;
    bus.busy      = (state_q != IDLE);
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter with a byte RAM model
module tb_mem_arbiter;
  logic clk;
  logic rst;

  mem_arbiter_if #(.ADDR_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .MEM_PRIO(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte RAM aliased on addr[9:0]; every address used below is distinct in those bits.
  logic [7:0] ram [1024];
  logic       ram_clr, pre_we;
  logic [9:0] pre_a;
  logic [7:0] pre_d;
  int         wr_count;

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
      wr_count <= 0;
    end else begin
      if (pre_we) ram[pre_a] <= pre_d;
      else if (bus.ram_wr) ram[bus.ram_addr[9:0]] <= bus.ram_dout;
      if (bus.ram_wr) wr_count <= wr_count + 1;
    end
    bus.ram_din <= ram[bus.ram_addr[9:0]];
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic preset(input logic [9:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1;
    pre_a  = a;
    pre_d  = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  typedef struct {
    bit          is_mem;
    bit          we;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n, mem_k, if_k, mem_cnt;
    bit got, seq_ok, quiet;
    vec_t v;

    vecs[0]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0100, 32'h0,         32'h4433_2211, 6};
    vecs[1]  = '{1'b1, 1'b1, 2'd2, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0,         5};
    vecs[2]  = '{1'b1, 1'b0, 2'd2, 32'h0000_0200, 32'h0,         32'hDEAD_BEEF, 6};
    vecs[3]  = '{1'b1, 1'b0, 2'd0, 32'h0000_0101, 32'h0,         32'h0000_0022, 3};
    vecs[4]  = '{1'b1, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0,         32'h0000_5AA5, 4};
    vecs[5]  = '{1'b1, 1'b1, 2'd1, 32'h0000_0202, 32'h1234_5678, 32'h0,         3};
    vecs[6]  = '{1'b1, 1'b0, 2'd3, 32'h0000_0200, 32'h0,         32'h5678_BEEF, 6};
    vecs[7]  = '{1'b1, 1'b1, 2'd0, 32'h0000_0300, 32'hAAAA_AA99, 32'h0,         2};
    vecs[8]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0300, 32'h0,         32'h0000_0099, 6};
    vecs[9]  = '{1'b1, 1'b1, 2'd3, 32'h0000_0104, 32'hCAFE_F00D, 32'h0,         5};
    vecs[10] = '{1'b0, 1'b0, 2'd2, 32'h0000_0102, 32'h0,         32'hF00D_4433, 6};
    vecs[11] = '{1'b1, 1'b0, 2'd1, 32'h0000_0105, 32'h0,         32'h0000_FEF0, 4};

    rst = 1'b1; ram_clr = 1'b1; pre_we = 1'b0; pre_a = '0; pre_d = '0;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.mem_req = 1'b0; bus.mem_we = 1'b0;
    bus.mem_len = '0; bus.mem_addr = '0; bus.mem_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    ram_clr = 1'b0;
    chk("rst_busy",      32'(bus.busy),     32'd0);
    chk("rst_ram_addr",  bus.ram_addr,      32'd0);
    chk("rst_ram_wr",    32'(bus.ram_wr),   32'd0);
    chk("rst_ram_dout",  32'(bus.ram_dout), 32'd0);
    chk("rst_if_rdata",  bus.if_rdata,      32'd0);
    chk("rst_mem_rdata", bus.mem_rdata,     32'd0);
    chk("rst_if_done",   32'(bus.if_done),  32'd0);
    chk("rst_mem_done",  32'(bus.mem_done), 32'd0);

    preset(10'h100, 8'h11);
    preset(10'h101, 8'h22);
    preset(10'h102, 8'h33);
    preset(10'h103, 8'h44);
    preset(10'h3FF, 8'hA5);
    preset(10'h000, 8'h5A);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      n = !v.is_mem ? 4 : (v.len == 2'd0 ? 1 : (v.len == 2'd1 ? 2 : 4));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_idle", i), 32'(bus.busy), 32'd0);
      if (v.is_mem) begin
        bus.mem_req = 1'b1; bus.mem_we = v.we; bus.mem_len = v.len;
        bus.mem_addr = v.addr; bus.mem_wdata = v.wdata;
      end else begin
        bus.if_req = 1'b1; bus.if_addr = v.addr;
      end
      k = 0; got = 1'b0; seq_ok = 1'b1;
      while (!got && k < 20) begin
        @(posedge clk);
        #1;
        k++;
        if (k <= n) begin
          if (bus.ram_addr !== v.addr + 32'(k - 1)) seq_ok = 1'b0;
          if (bus.ram_wr !== v.we) seq_ok = 1'b0;
          if (v.we && bus.ram_dout !== v.wdata[8*(k-1) +: 8]) seq_ok = 1'b0;
        end
        if (v.is_mem ? bus.if_done : bus.mem_done) seq_ok = 1'b0;
        got = v.is_mem ? bus.mem_done : bus.if_done;
      end
      chk($sformatf("v%0d_latency", i), 32'(k), 32'(v.exp_lat));
      chk($sformatf("v%0d_port_seq", i), 32'(seq_ok), 32'd1);
      if (!v.we)
        chk($sformatf("v%0d_rdata", i), v.is_mem ? bus.mem_rdata : bus.if_rdata, v.exp_rdata);
      bus.mem_req = 1'b0;
      bus.if_req  = 1'b0;
    end

    // Simultaneous requests: MEM byte load goes first, IF waits and is granted right after DONE.
    @(posedge clk);
    #1;
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_len = 2'd0; bus.mem_addr = 32'h100;
    bus.if_req  = 1'b1; bus.if_addr = 32'h100;
    k = 0; mem_k = -1; if_k = -1; mem_cnt = 0;
    while (if_k < 0 && k < 30) begin
      @(posedge clk);
      #1;
      k++;
      if (bus.mem_done) begin
        mem_cnt++;
        if (mem_k < 0) mem_k = k;
        chk("prio_mem_rdata", bus.mem_rdata, 32'h0000_0011);
        bus.mem_req = 1'b0;
      end
      if (bus.if_done) begin
        if_k = k;
        chk("prio_if_rdata", bus.if_rdata, 32'h4433_2211);
        bus.if_req = 1'b0;
      end
    end
    chk("prio_mem_done_cycle", 32'(mem_k), 32'd3);
    chk("prio_if_done_cycle",  32'(if_k),  32'd10);
    chk("prio_mem_done_count", 32'(mem_cnt), 32'd1);
    chk("prio_mem_rdata_hold", bus.mem_rdata, 32'h0000_0011);

    // Reset during the second WR cycle of a word store.
    @(posedge clk);
    #1;
    mem_cnt = wr_count;
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_len = 2'd2;
    bus.mem_addr = 32'h3F0; bus.mem_wdata = 32'h8765_4321;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_ram_wr",   32'(bus.ram_wr),   32'd0);
    chk("abort_busy",     32'(bus.busy),     32'd0);
    chk("abort_mem_done", 32'(bus.mem_done), 32'd0);
    rst = 1'b0;
    bus.mem_req = 1'b0;
    quiet = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus.mem_done || bus.ram_wr) quiet = 1'b0;
    end
    chk("abort_quiet",   32'(quiet), 32'd1);
    chk("abort_writes",  32'(wr_count - mem_cnt), 32'd2);
    chk("abort_byte0",   32'(ram[10'h3F0]), 32'h21);
    chk("abort_byte1",   32'(ram[10'h3F1]), 32'h43);
    chk("abort_byte2",   32'(ram[10'h3F2]), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
